// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared types and constants
// for the wait-state LC3 memory.
package lc3_mem_pkg;

    localparam int WAIT_CNT_W  = 4;
    localparam int FAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_BUSY,
        MEM_RESP
    } mem_state_t;

    function automatic logic [FAULT_CNT_W-1:0] sat_inc(
        input logic [FAULT_CNT_W-1:0] v
    );
        return (&v) ? v : v + FAULT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/lc3_wait_mem_if.sv
// lc3_wait_mem_if: LC3 memory-side bus
// with request/ready handshake.
interface lc3_wait_mem_if
    import lc3_mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16
) ();

    logic                   memreq;
    logic                   memwe;
    logic [ADDRESS_WIDTH-1:0] mar;
    logic [DATA_WIDTH-1:0]  mdr;
    logic [DATA_WIDTH-1:0]  memOut;
    logic                   mem_ready;
    logic                   mem_fault;
    logic                   busy;
    logic [FAULT_CNT_W-1:0] fault_count;

    modport master (
        output memreq, memwe, mar, mdr,
        input  memOut, mem_ready, mem_fault,
        input  busy, fault_count
    );

    modport slave (
        input  memreq, memwe, mar, mdr,
        output memOut, mem_ready, mem_fault,
        output busy, fault_count
    );

endinterface

// File: rtl/lc3_mem_array.sv
// lc3_mem_array: single-port word array,
// synchronous write and read, no reset.
module lc3_mem_array #(
    parameter int DEPTH      = 65536,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = 16
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [IDX_W-1:0]      addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/lc3_wait_mem.sv
// lc3_wait_mem: LC3 memory with wait states,
// populated-depth range check and fault count.
module lc3_wait_mem
    import lc3_mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 2**ADDRESS_WIDTH,
    parameter int WAIT_STATES   = 0
) (
    input logic           clk,
    input logic           reset,
    lc3_wait_mem_if.slave bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDRESS_WIDTH:0] DEPTH_W =
        (ADDRESS_WIDTH+1)'(DEPTH);

    mem_state_t state, state_n;

    logic [WAIT_CNT_W-1:0]    wait_cnt;
    logic [ADDRESS_WIDTH-1:0] mar_q;
    logic [DATA_WIDTH-1:0]    mdr_q;
    logic                     we_q;
    logic [DATA_WIDTH-1:0]    hold_q;
    logic                     src_arr;
    logic                     ready_q;
    logic                     fault_q;
    logic                     busy_q;
    logic [FAULT_CNT_W-1:0]   fcnt_q;
    logic [DATA_WIDTH-1:0]    arr_rdata;

    logic accept;
    logic perform;
    logic in_range;

    assign in_range = {1'b0, mar_q} < DEPTH_W;
    assign perform  = (state == MEM_BUSY) &&
                      (wait_cnt == '0);
    assign accept   = bus.memreq &&
                      ((state == MEM_IDLE) ||
                       (state == MEM_RESP));

    always_comb begin
        state_n = state;
        unique case (state)
            MEM_IDLE: begin
                if (bus.memreq) state_n = MEM_BUSY;
            end
            MEM_BUSY: begin
                if (wait_cnt == '0) state_n = MEM_RESP;
            end
            MEM_RESP: begin
                state_n = bus.memreq ? MEM_BUSY
                                     : MEM_IDLE;
            end
            default: state_n = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= MEM_IDLE;
            wait_cnt <= '0;
            mar_q    <= '0;
            mdr_q    <= '0;
            we_q     <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                wait_cnt <= WAIT_CNT_W'(WAIT_STATES);
                mar_q    <= bus.mar;
                mdr_q    <= bus.mdr;
                we_q     <= bus.memwe;
            end else if (state == MEM_BUSY &&
                         wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    // Reads land in the array's own output register;
    // writes and faults land in hold_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q  <= '0;
            src_arr <= 1'b0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            busy_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            ready_q <= (state_n == MEM_RESP);
            busy_q  <= (state_n == MEM_BUSY);
            fault_q <= perform && !in_range;
            if (perform) begin
                src_arr <= in_range && !we_q;
                hold_q  <= in_range ? mdr_q : '0;
                if (!in_range) fcnt_q <= sat_inc(fcnt_q);
            end
        end
    end

    lc3_mem_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (perform && in_range),
        .we    (we_q),
        .addr  (mar_q[IDX_W-1:0]),
        .wdata (mdr_q),
        .rdata (arr_rdata)
    );

    assign bus.memOut      = src_arr ? arr_rdata : hold_q;
    assign bus.mem_ready   = ready_q;
    assign bus.mem_fault   = fault_q;
    assign bus.busy        = busy_q;
    assign bus.fault_count = fcnt_q;

endmodule

// File: doc/lc3_wait_mem.md
# lc3_wait_mem

Parametrised single-port word memory for the LC3 testbench/SoC. It replaces a fixed zero-latency memory with a request/ready handshake, a configurable number of wait states, a configurable populated depth and out-of-range fault reporting. It sits on the memory side of the LC3 bus (mar/mdr/memwe in, memOut out) and lets processor and bench be exercised against slow memory.

## Interface
Parameters:
- ADDRESS_WIDTH, 16, width of mar.
- DATA_WIDTH, 16, width of mdr/memOut.
- DEPTH, 2**ADDRESS_WIDTH, populated words; legal range 1..2**ADDRESS_WIDTH.
- WAIT_STATES, 0, extra cycles per access; range 0..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- memreq  input  1  access request.
- memwe  input  1  1 = write, 0 = read; qualified by memreq.
- mar  input  ADDRESS_WIDTH  word address.
- mdr  input  DATA_WIDTH  write data.
- memOut  output  DATA_WIDTH  read data, or echo of written data.
- mem_ready  output  1  one-cycle completion pulse.
- mem_fault  output  1  completed access was out of range; valid only with mem_ready.
- busy  output  1  high in MEM_BUSY.
- fault_count  output  8  saturating count of faulted accesses.

## Operation
- States: MEM_IDLE, MEM_BUSY, MEM_RESP.
- MEM_IDLE: memreq=1 at an edge accepts the request. mar, mdr and memwe are captured, wait_cnt is loaded with WAIT_STATES, and the state moves to MEM_BUSY.
- MEM_BUSY: if wait_cnt != 0, decrement. Otherwise perform the access and go to MEM_RESP.
  - In-range read (mar < DEPTH): memOut <= mem[mar].
  - In-range write: mem[mar] <= mdr and memOut <= mdr.
  - Out-of-range access: no array write, memOut <= 0, mem_fault <= 1, and fault_count increments, saturating at 8'hFF.
- MEM_RESP: mem_ready=1 for exactly this cycle.
  - memreq=1 at the closing edge accepts a new request; go to MEM_BUSY.
  - Otherwise go to MEM_IDLE.
- Requester rules:
  - Hold memreq, mar, mdr and memwe stable from assertion until the cycle mem_ready is high.
  - Deassert memreq or present the next request in that same cycle. memreq high at the edge ending MEM_RESP is always treated as a new request.
- memreq during MEM_BUSY is ignored; the captured values are used.
- memOut holds its value until the next completed access. mem_fault clears when leaving MEM_RESP.
- Array contents are not reset and are X until written.
- Address compare is unsigned on the full ADDRESS_WIDTH. When DEPTH = 2**ADDRESS_WIDTH, faults never occur.

## Timing
- Reset values: state MEM_IDLE, memOut 0, mem_ready 0, mem_fault 0, busy 0, fault_count 0, wait_cnt 0.
- Latency: request accepted at edge E0 gives mem_ready high in the cycle after edge E0+WAIT_STATES+1.
- Throughput with back-to-back requests: one access per WAIT_STATES+2 cycles.
- WAIT_STATES=0: MEM_BUSY lasts one cycle.
- Reset mid-operation: a pending access is abandoned and a not-yet-performed write never reaches the array. A write already performed stays in the array.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package lc3_mem_pkg:
  - typedef enum mem_state_t {MEM_IDLE, MEM_BUSY, MEM_RESP}.
  - Constants WAIT_CNT_W=4 and FAULT_CNT_W=8.
- Sub-module lc3_mem_array: DEPTH x DATA_WIDTH, single port, synchronous write and synchronous read, no reset.
- Top level holds the FSM, capture registers, wait counter, range check and fault counter.

## Test plan
- Reset, then write 16'h1234 to 16'h0010 and read 16'h0010 with WAIT_STATES=0 -> read mem_ready pulse 2 cycles after accept, memOut=16'h1234, mem_fault=0.
- WAIT_STATES=3, read of a written address -> busy high 4 cycles, mem_ready 5 cycles after accept, single pulse.
- DEPTH=256, write 16'hBEEF to 16'h0100, then read 16'h0100 -> both accesses fault, memOut=0, fault_count=2, array unchanged.
- Back-to-back writes to 16'h0001 (16'hAAAA) and 16'h0002 (16'h5555), memreq held through MEM_RESP -> two mem_ready pulses spaced WAIT_STATES+2 cycles; later reads return both values.
- Assert reset during MEM_BUSY of a write (WAIT_STATES=5) to 16'h0020 -> all outputs 0 immediately; a later read of 16'h0020 returns the prior contents, not the write data.
- 300 out-of-range accesses -> fault_count saturates at 8'hFF.
